// File: rtl/lut_cfg_sequencer_if.sv
// Config, lookup and status signals of the LUT sequencer, bundled for port use.
interface lut_cfg_sequencer_if #(
  parameter int unsigned ADDR_W = 4
) ();

  logic              cfg_start;
  logic              cfg_clear;
  logic              cfg_valid;
  logic              cfg_bit;
  logic              cfg_ready;
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_ready;
  logic              rsp_valid;
  logic              rsp_data;
  logic              busy;
  logic              loaded;

  // Requester side: config/CSR path and the evaluation datapath.
  modport master (
    output cfg_start, cfg_clear, cfg_valid, cfg_bit, lk_valid, lk_addr,
    input  cfg_ready, lk_ready, rsp_valid, rsp_data, busy, loaded
  );

  // Sequencer side.
  modport slave (
    input  cfg_start, cfg_clear, cfg_valid, cfg_bit, lk_valid, lk_addr,
    output cfg_ready, lk_ready, rsp_valid, rsp_data, busy, loaded
  );

endinterface

// File: rtl/lut_cfg_sequencer.sv
// DEPTH x 1-bit truth-table LUT with serial load, clear sweep and 1-cycle lookups.
module lut_cfg_sequencer #(
  parameter int unsigned ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  lut_cfg_sequencer_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0]    table_q, table_d;
  logic                loaded_q, loaded_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_data_q, rsp_data_d;

  logic ptr_last;
  logic lk_fire;

  assign ptr_last = (ptr_q == {ADDR_W{1'b1}});
  // Lookup acceptance depends only on registered state plus the request itself.
  assign lk_fire  = bus.lk_valid && (state_q == StReady);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; clear has priority over start everywhere except CLEAR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cfg_clear) begin
          state_d = StClear;
        end else if (bus.cfg_start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (bus.cfg_clear) begin
          state_d = StClear;
        end else if (!bus.cfg_start && bus.cfg_valid && ptr_last) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (bus.cfg_clear) begin
          state_d = StClear;
        end else if (bus.cfg_start) begin
          state_d = StLoad;
        end
      end
      StClear: begin
        if (ptr_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state and registered datapath only.
  always_comb begin
    bus.cfg_ready = (state_q == StLoad);
    bus.lk_ready  = (state_q == StReady);
    bus.busy      = (state_q == StLoad) || (state_q == StClear);
    bus.loaded    = loaded_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_data  = rsp_data_q;
  end

  // Datapath next values: pointer, table writes, loaded flag, lookup response.
  always_comb begin
    ptr_d    = ptr_q;
    table_d  = table_q;
    loaded_d = loaded_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cfg_clear || bus.cfg_start) begin
          ptr_d = '0;
        end
      end
      StLoad: begin
        if (bus.cfg_clear) begin
          // Partial contents stay until the sweep overwrites them.
          ptr_d    = '0;
          loaded_d = 1'b0;
        end else if (bus.cfg_start) begin
          // Restart drops any beat presented in the same cycle.
          ptr_d = '0;
        end else if (bus.cfg_valid) begin
          table_d[ptr_q] = bus.cfg_bit;
          ptr_d          = ptr_q + 1'b1;
          if (ptr_last) begin
            loaded_d = 1'b1;
          end
        end
      end
      StReady: begin
        if (bus.cfg_clear || bus.cfg_start) begin
          ptr_d    = '0;
          loaded_d = 1'b0;
        end
      end
      StClear: begin
        table_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_last) begin
          loaded_d = 1'b0;
        end
      end
      default: ptr_d = '0;
    endcase

    // Read uses table_q, so a lookup coinciding with a mode change sees the old table.
    rsp_valid_d = lk_fire;
    rsp_data_d  = lk_fire ? table_q[bus.lk_addr] : rsp_data_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      table_q     <= '0;
      loaded_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      table_q     <= table_d;
      loaded_q    <= loaded_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
